// File: rtl/line_dma_host_if.sv
// Host-side channels of the line DMA controller: request, write-beat and read-beat.
// The master modport is the DMA controller; the slave modport is the host or memory port.
interface line_dma_host_if;
  logic        host_req_valid;
  logic        host_req_ready;
  logic        host_req_wr;
  logic [31:0] host_req_addr;
  logic [63:0] host_wdata;
  logic        host_wvalid;
  logic        host_wready;
  logic [63:0] host_rdata;
  logic        host_rvalid;

  modport master (
    output host_req_valid, host_req_wr, host_req_addr, host_wdata, host_wvalid,
    input  host_req_ready, host_wready, host_rdata, host_rvalid
  );

  modport slave (
    input  host_req_valid, host_req_wr, host_req_addr, host_wdata, host_wvalid,
    output host_req_ready, host_wready, host_rdata, host_rvalid
  );
endinterface

// File: rtl/line_dma_ctrl.sv
// Moves one 64-byte cache line to or from the host as eight 64-bit beats.
// One transaction at a time; cache-side inputs are only looked at while idle.
module line_dma_ctrl (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             op,
  input  logic [31:0]            addr,
  input  logic [511:0]           wdata,
  output logic [511:0]           rdata,
  output logic                   rd_valid,
  output logic                   tx_done,
  output logic                   busy,
  line_dma_host_if.master        host
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  state_t         r_state;
  state_t         w_next;
  logic [2:0]     r_beat;
  logic           r_wr;
  logic [31:0]    r_addr;
  logic [511:0]   r_line;
  logic [511:0]   r_rdata;
  logic [511:0]   w_line_rd;
  logic           w_start;
  logic           w_last_beat;

  assign w_start     = (op == OP_READ) || (op == OP_WRITE);
  assign w_last_beat = (r_beat == 3'd7);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_REQ;
      S_REQ:   if (host.host_req_ready) w_next = r_wr ? S_WDATA : S_RDATA;
      S_WDATA: if (host.host_wready && w_last_beat) w_next = S_DONE;
      S_RDATA: if (host.host_rvalid && w_last_beat) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    host.host_req_valid = 1'b0;
    host.host_req_wr    = 1'b0;
    host.host_req_addr  = '0;
    host.host_wvalid    = 1'b0;
    host.host_wdata     = '0;
    tx_done             = 1'b0;
    rd_valid            = 1'b0;
    busy                = (r_state != S_IDLE);
    case (r_state)
      S_REQ: begin
        host.host_req_valid = 1'b1;
        host.host_req_wr    = r_wr;
        host.host_req_addr  = r_addr;
      end
      S_WDATA: begin
        host.host_wvalid = 1'b1;
        host.host_wdata  = r_line[{r_beat, 6'd0} +: 64];
      end
      S_DONE: begin
        tx_done  = 1'b1;
        rd_valid = !r_wr;
      end
      default: ;
    endcase
  end

  // Line buffer with the incoming read beat merged in, so the final beat
  // reaches rdata on the same edge that enters DONE.
  always_comb begin
    w_line_rd = r_line;
    w_line_rd[{r_beat, 6'd0} +: 64] = host.host_rdata;
  end

  // NOTE: the line buffer is reset because a reset must discard any partial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat  <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_line  <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr <= addr & 32'hFFFF_FFC0;
            r_wr   <= (op == OP_WRITE);
            r_line <= wdata;
          end
        end
        S_REQ: begin
          if (host.host_req_ready) r_beat <= '0;
        end
        S_WDATA: begin
          if (host.host_wready) r_beat <= r_beat + 3'd1;
        end
        S_RDATA: begin
          if (host.host_rvalid) begin
            r_line <= w_line_rd;
            r_beat <= r_beat + 3'd1;
            if (w_last_beat) r_rdata <= w_line_rd;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata = r_rdata;

endmodule

// File: tb/tb_line_dma_ctrl.sv
// Directed self-checking bench for line_dma_ctrl: read, write, stalls,
// mid-transaction input changes, reset abort, reserved op and back-to-back use.
module tb_line_dma_ctrl;

  logic         clk;
  logic         rst_n;
  logic [1:0]   op;
  logic [31:0]  addr;
  logic [511:0] wdata;
  logic [511:0] rdata;
  logic         rd_valid;
  logic         tx_done;
  logic         busy;

  int n_tests;
  int n_fail;
  logic [511:0] last_rd;

  line_dma_host_if host_if ();

  line_dma_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .tx_done  (tx_done),
    .busy     (busy),
    .host     (host_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Supplies n read beats, beat k = m*(k+1), and returns the line they form.
  task automatic feed_read(input logic [63:0] m, input int n, output logic [511:0] line);
    line = '0;
    host_if.host_rvalid = 1'b1;
    for (int k = 0; k < n; k++) begin
      host_if.host_rdata = m * 64'(k + 1);
      line[k*64 +: 64]   = m * 64'(k + 1);
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    op = 2'b00; addr = '0; wdata = '0;
    host_if.host_req_ready = 1'b0;
    host_if.host_wready    = 1'b0;
    host_if.host_rvalid    = 1'b0;
    host_if.host_rdata     = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (tx_done !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: tx_done=%b rd_valid=%b want 0/0", tx_done, rd_valid); end
    n_tests++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_tests++; if (host_if.host_req_valid !== 1'b0 || host_if.host_req_addr !== '0 || host_if.host_req_wr !== 1'b0) begin n_fail++; $display("FAIL reset_req: valid=%b addr=%h wr=%b want 0/0/0", host_if.host_req_valid, host_if.host_req_addr, host_if.host_req_wr); end
    n_tests++; if (host_if.host_wvalid !== 1'b0 || host_if.host_wdata !== '0) begin n_fail++; $display("FAIL reset_wbeat: wvalid=%b wdata=%h want 0/0", host_if.host_wvalid, host_if.host_wdata); end
  endtask

  task automatic test_read();
    logic [511:0] exp;
    logic [63:0]  m;
    m = 64'h1111_1111_1111_1111;
    exp = '0;
    op = 2'b01; addr = 32'h0000_1234;
    host_if.host_req_ready = 1'b1;
    host_if.host_rvalid    = 1'b1;
    host_if.host_rdata     = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    op = 2'b00;
    n_tests++; if (host_if.host_req_valid !== 1'b1 || host_if.host_req_addr !== 32'h0000_1200 || host_if.host_req_wr !== 1'b0) begin n_fail++; $display("FAIL read_req: valid=%b addr=%h wr=%b want 1/00001200/0", host_if.host_req_valid, host_if.host_req_addr, host_if.host_req_wr); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL read_busy: got %b want 1", busy); end
    tick();
    n_tests++; if (host_if.host_req_valid !== 1'b0) begin n_fail++; $display("FAIL read_req_drop: got %b want 0", host_if.host_req_valid); end
    for (int k = 0; k < 8; k++) begin
      host_if.host_rdata = m * 64'(k + 1);
      exp[k*64 +: 64]    = m * 64'(k + 1);
      tick();
      if (k < 7) begin
        n_tests++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL read_early_done: beat %0d tx_done=%b want 0", k, tx_done); end
      end
    end
    n_tests++; if (tx_done !== 1'b1 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL read_latency: tx_done=%b rd_valid=%b want 1/1", tx_done, rd_valid); end
    n_tests++; if (rdata[63:0] !== 64'h1111_1111_1111_1111) begin n_fail++; $display("FAIL read_beat0: got %h want 1111111111111111", rdata[63:0]); end
    n_tests++; if (rdata[511:448] !== 64'h8888_8888_8888_8888) begin n_fail++; $display("FAIL read_beat7: got %h want 8888888888888888", rdata[511:448]); end
    n_tests++; if (rdata !== exp) begin n_fail++; $display("FAIL read_line: got %h want %h", rdata, exp); end
    host_if.host_rvalid = 1'b0;
    tick();
    n_tests++; if (tx_done !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL read_idle: tx_done=%b rd_valid=%b busy=%b want 0/0/0", tx_done, rd_valid, busy); end
    last_rd = exp;
  endtask

  task automatic test_write();
    logic [511:0] wl;
    int b;
    int cyc;
    wl = 512'hFF;
    op = 2'b10; addr = 32'h0000_0040; wdata = wl;
    host_if.host_req_ready = 1'b1;
    host_if.host_wready    = 1'b0;
    tick();
    op = 2'b00; wdata = '1;
    n_tests++; if (host_if.host_req_valid !== 1'b1 || host_if.host_req_addr !== 32'h0000_0040 || host_if.host_req_wr !== 1'b1) begin n_fail++; $display("FAIL write_req: valid=%b addr=%h wr=%b want 1/00000040/1", host_if.host_req_valid, host_if.host_req_addr, host_if.host_req_wr); end
    n_tests++; if (host_if.host_wvalid !== 1'b0) begin n_fail++; $display("FAIL write_wvalid_in_req: got %b want 0", host_if.host_wvalid); end
    tick();
    b = 0; cyc = 0;
    while (b < 8 && cyc < 40) begin
      host_if.host_wready = (cyc % 2 == 0);
      n_tests++; if (host_if.host_wvalid !== 1'b1 || host_if.host_wdata !== wl[b*64 +: 64]) begin n_fail++; $display("FAIL write_beat%0d: wvalid=%b wdata=%h want 1/%h", b, host_if.host_wvalid, host_if.host_wdata, wl[b*64 +: 64]); end
      tick();
      if (host_if.host_wready) b++;
      cyc++;
    end
    n_tests++; if (b != 8) begin n_fail++; $display("FAIL write_timeout: beats=%0d want 8", b); end
    n_tests++; if (tx_done !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL write_done: tx_done=%b rd_valid=%b want 1/0", tx_done, rd_valid); end
    n_tests++; if (rdata !== last_rd) begin n_fail++; $display("FAIL write_rdata_kept: got %h want %h", rdata, last_rd); end
    host_if.host_wready = 1'b0;
    tick();
    n_tests++; if (tx_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL write_single_done: tx_done=%b busy=%b want 0/0", tx_done, busy); end
  endtask

  task automatic test_req_stall();
    logic [511:0] exp;
    op = 2'b01; addr = 32'h0000_ABCD;
    host_if.host_req_ready = 1'b0;
    host_if.host_rvalid    = 1'b1;
    host_if.host_rdata     = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    op = 2'b00;
    for (int i = 0; i < 6; i++) begin
      n_tests++; if (host_if.host_req_valid !== 1'b1 || host_if.host_req_addr !== 32'h0000_ABC0 || busy !== 1'b1 || host_if.host_wvalid !== 1'b0) begin n_fail++; $display("FAIL stall_req_c%0d: valid=%b addr=%h busy=%b wvalid=%b want 1/0000abc0/1/0", i, host_if.host_req_valid, host_if.host_req_addr, busy, host_if.host_wvalid); end
      if (i < 5) tick();
    end
    host_if.host_req_ready = 1'b1;
    tick();
    feed_read(64'h0202_0202_0202_0202, 8, exp);
    n_tests++; if (tx_done !== 1'b1 || rd_valid !== 1'b1 || rdata !== exp) begin n_fail++; $display("FAIL stall_read: tx_done=%b rd_valid=%b rdata=%h want 1/1/%h", tx_done, rd_valid, rdata, exp); end
    host_if.host_rvalid = 1'b0;
    tick();
    last_rd = exp;
  endtask

  task automatic test_op_change();
    logic [511:0] exp;
    op = 2'b01; addr = 32'h0000_2040;
    host_if.host_req_ready = 1'b1;
    tick();
    tick();
    op = 2'b10; addr = 32'hFFFF_FFFF; wdata = '1;
    feed_read(64'h0303_0303_0303_0303, 8, exp);
    n_tests++; if (tx_done !== 1'b1 || rd_valid !== 1'b1 || rdata !== exp) begin n_fail++; $display("FAIL opchg_read: tx_done=%b rd_valid=%b rdata=%h want 1/1/%h", tx_done, rd_valid, rdata, exp); end
    n_tests++; if (host_if.host_wvalid !== 1'b0) begin n_fail++; $display("FAIL opchg_wvalid: got %b want 0", host_if.host_wvalid); end
    host_if.host_rvalid = 1'b0;
    last_rd = exp;
    tick();
    n_tests++; if (busy !== 1'b0 || host_if.host_req_valid !== 1'b0) begin n_fail++; $display("FAIL opchg_idle: busy=%b req_valid=%b want 0/0", busy, host_if.host_req_valid); end
    tick();
    n_tests++; if (host_if.host_req_valid !== 1'b1 || host_if.host_req_wr !== 1'b1 || host_if.host_req_addr !== 32'hFFFF_FFC0) begin n_fail++; $display("FAIL opchg_new_req: valid=%b wr=%b addr=%h want 1/1/ffffffc0", host_if.host_req_valid, host_if.host_req_wr, host_if.host_req_addr); end
    op = 2'b00;
    host_if.host_wready = 1'b1;
    tick();
    n_tests++; if (host_if.host_wdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL opchg_wdata: got %h want ffffffffffffffff", host_if.host_wdata); end
    repeat (8) tick();
    n_tests++; if (tx_done !== 1'b1 || rd_valid !== 1'b0 || rdata !== last_rd) begin n_fail++; $display("FAIL opchg_write_done: tx_done=%b rd_valid=%b rdata=%h want 1/0/%h", tx_done, rd_valid, rdata, last_rd); end
    host_if.host_wready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [511:0] exp;
    op = 2'b01; addr = 32'h0000_0080;
    host_if.host_req_ready = 1'b1;
    tick();
    op = 2'b00;
    tick();
    feed_read(64'h0404_0404_0404_0404, 4, exp);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0 || tx_done !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: busy=%b tx_done=%b rd_valid=%b want 0/0/0", busy, tx_done, rd_valid); end
    n_tests++; if (rdata !== '0) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 0", rdata); end
    n_tests++; if (host_if.host_req_valid !== 1'b0 || host_if.host_req_addr !== '0 || host_if.host_wvalid !== 1'b0 || host_if.host_wdata !== '0) begin n_fail++; $display("FAIL rstmid_host: req_valid=%b addr=%h wvalid=%b wdata=%h want all 0", host_if.host_req_valid, host_if.host_req_addr, host_if.host_wvalid, host_if.host_wdata); end
    host_if.host_rvalid = 1'b0;
    tick();
    n_tests++; if (tx_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_hold: tx_done=%b busy=%b want 0/0", tx_done, busy); end
    op = 2'b01; addr = 32'h0000_0100;
    rst_n = 1'b1;
    tick();
    op = 2'b00;
    n_tests++; if (host_if.host_req_valid !== 1'b1 || host_if.host_req_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL rstmid_first_op: valid=%b addr=%h want 1/00000100", host_if.host_req_valid, host_if.host_req_addr); end
    tick();
    feed_read(64'h0505_0505_0505_0505, 8, exp);
    n_tests++; if (tx_done !== 1'b1 || rd_valid !== 1'b1 || rdata !== exp) begin n_fail++; $display("FAIL rstmid_reread: tx_done=%b rd_valid=%b rdata=%h want 1/1/%h", tx_done, rd_valid, rdata, exp); end
    host_if.host_rvalid = 1'b0;
    tick();
    last_rd = exp;
  endtask

  task automatic test_reserved_op();
    op = 2'b11; addr = 32'h0000_0300;
    host_if.host_req_ready = 1'b1;
    host_if.host_wready    = 1'b1;
    host_if.host_rvalid    = 1'b1;
    host_if.host_rdata     = 64'hABCD_ABCD_ABCD_ABCD;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++; if (busy !== 1'b0 || host_if.host_req_valid !== 1'b0 || host_if.host_wvalid !== 1'b0 || tx_done !== 1'b0) begin n_fail++; $display("FAIL reserved_c%0d: busy=%b req_valid=%b wvalid=%b tx_done=%b want 0/0/0/0", i, busy, host_if.host_req_valid, host_if.host_wvalid, tx_done); end
    end
    n_tests++; if (rdata !== last_rd) begin n_fail++; $display("FAIL reserved_rdata: got %h want %h", rdata, last_rd); end
    op = 2'b00;
    host_if.host_wready = 1'b0;
    host_if.host_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [511:0] wl;
    logic [511:0] exp;
    for (int k = 0; k < 8; k++) wl[k*64 +: 64] = 64'hC0DE_0000_0000_0000 + 64'(k);
    op = 2'b10; addr = 32'h0000_1000; wdata = wl;
    host_if.host_req_ready = 1'b1;
    host_if.host_wready    = 1'b1;
    tick();
    op = 2'b01; addr = 32'h0000_2000;
    tick();
    for (int b = 0; b < 8; b++) begin
      n_tests++; if (host_if.host_wvalid !== 1'b1 || host_if.host_wdata !== wl[b*64 +: 64]) begin n_fail++; $display("FAIL b2b_wbeat%0d: wvalid=%b wdata=%h want 1/%h", b, host_if.host_wvalid, host_if.host_wdata, wl[b*64 +: 64]); end
      tick();
    end
    n_tests++; if (tx_done !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_wdone: tx_done=%b rd_valid=%b want 1/0", tx_done, rd_valid); end
    host_if.host_wready = 1'b0;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: busy=%b want 0", busy); end
    tick();
    op = 2'b00;
    n_tests++; if (host_if.host_req_valid !== 1'b1 || host_if.host_req_wr !== 1'b0 || host_if.host_req_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL b2b_rreq: valid=%b wr=%b addr=%h want 1/0/00002000", host_if.host_req_valid, host_if.host_req_wr, host_if.host_req_addr); end
    tick();
    feed_read(64'h0606_0606_0606_0606, 8, exp);
    n_tests++; if (tx_done !== 1'b1 || rd_valid !== 1'b1 || rdata !== exp) begin n_fail++; $display("FAIL b2b_read: tx_done=%b rd_valid=%b rdata=%h want 1/1/%h", tx_done, rd_valid, rdata, exp); end
    host_if.host_rvalid = 1'b0;
    tick();
    last_rd = exp;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    last_rd = '0;
    test_reset();
    test_read();
    test_write();
    test_req_stall();
    test_op_change();
    test_reset_mid();
    test_reserved_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
